// File: rtl/alu_seq_pkg.sv
// Shared types and ALU control-word helpers for the multi-cycle ALU sequencer.
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD16 = 3'd0,
    OP_SUB16 = 3'd1,
    OP_ADC16 = 3'd2,
    OP_SBC16 = 3'd3,
    OP_SHIFT = 3'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO,
    ST_HI,
    ST_SHF,
    ST_DONE
  } state_e;

  localparam int CTL_SHIFT    = 7;
  localparam int CTL_TAKEFLAG = 6;
  localparam int CTL_SUB      = 5;
  localparam int CTL_NOFLIP   = 0;

  localparam logic [8:0] ALU_NOP = 9'(1) << CTL_NOFLIP;

  // Branch and flip fields always stay zero; only the op fields vary.
  function automatic logic [8:0] mk_ctl(input logic shift, input logic [1:0] kind,
                                        input logic sub, input logic take);
    logic [8:0] w;
    w = ALU_NOP;
    if (shift) begin
      w[CTL_SHIFT]              = 1'b1;
      w[CTL_TAKEFLAG:CTL_SUB]   = kind;
    end else begin
      w[CTL_TAKEFLAG]           = take;
      w[CTL_SUB]                = sub;
    end
    return w;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Sequencer that splits 16-bit add/sub and N-bit shifts into 8-bit ALU passes.
// Optional ALU_SEQ_PERF_EN adds saturating busy-cycle and completed-op counters.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int CNT_W = 3
`ifdef ALU_SEQ_PERF_EN
  , parameter int PERF_W = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [1:0]       req_kind,
  input  logic [CNT_W-1:0] req_cnt,
  input  logic [15:0]      req_a,
  input  logic [15:0]      req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             flag_q,
  output logic [7:0]       alu_srcA,
  output logic [7:0]       alu_srcB,
  output logic [7:0]       alu_srcC,
  output logic             alu_flagin,
  output logic             alu_flipin,
  output logic [8:0]       alu_control,
  input  logic [7:0]       alu_result,
  input  logic             alu_flagout
`ifdef ALU_SEQ_PERF_EN
  , output logic [PERF_W-1:0] perf_busy
  , output logic [PERF_W-1:0] perf_ops
`endif
);

  state_e           state_q;
  op_e              op_q;
  logic [1:0]       kind_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      a_q;
  logic [15:0]      b_q;
  logic [7:0]       byte_q;   // LO result for add/sub, running byte for shifts
  logic             chain_q;
  logic             rsp_valid_q;
  logic [15:0]      rsp_data_q;

  logic is_sub;
  logic take_flag;

  assign is_sub    = (op_q == OP_SUB16) || (op_q == OP_SBC16);
  assign take_flag = (op_q == OP_ADC16) || (op_q == OP_SBC16);

  assign req_ready  = (state_q == ST_IDLE);
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign alu_srcC   = 8'h00;
  assign alu_flipin = 1'b0;

  always_comb begin
    alu_srcA    = 8'h00;
    alu_srcB    = 8'h00;
    alu_flagin  = 1'b0;
    alu_control = ALU_NOP;
    case (state_q)
      ST_LO: begin
        alu_srcA    = a_q[7:0];
        alu_srcB    = b_q[7:0];
        alu_control = mk_ctl(1'b0, 2'b00, is_sub, take_flag);
        alu_flagin  = take_flag & flag_q;
      end
      ST_HI: begin
        alu_srcA    = a_q[15:8];
        alu_srcB    = b_q[15:8];
        alu_control = mk_ctl(1'b0, 2'b00, is_sub, 1'b1);
        alu_flagin  = chain_q;
      end
      ST_SHF: begin
        alu_srcA    = byte_q;
        alu_control = mk_ctl(1'b1, kind_q, 1'b0, 1'b0);
        alu_flagin  = chain_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_ADD16;
      kind_q      <= 2'b00;
      cnt_q       <= '0;
      a_q         <= 16'h0000;
      b_q         <= 16'h0000;
      byte_q      <= 8'h00;
      chain_q     <= 1'b0;
      flag_q      <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 16'h0000;
    end else begin
      case (state_q)
        ST_IDLE: if (req_valid) begin
          op_q    <= op_e'(req_op);
          kind_q  <= req_kind;
          cnt_q   <= req_cnt;
          a_q     <= req_a;
          b_q     <= req_b;
          byte_q  <= req_a[7:0];
          // Shifts seed the chain with the architectural flag for the first pass.
          chain_q <= flag_q;
          case (op_e'(req_op))
            OP_ADD16, OP_SUB16, OP_ADC16, OP_SBC16: state_q <= ST_LO;
            OP_SHIFT: begin
              if (req_cnt == '0) begin
                state_q     <= ST_DONE;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= {8'h00, req_a[7:0]};
              end else begin
                state_q <= ST_SHF;
              end
            end
            default: begin
              state_q     <= ST_DONE;
              rsp_valid_q <= 1'b1;
              rsp_data_q  <= 16'h0000;
            end
          endcase
        end
        ST_LO: begin
          byte_q  <= alu_result;
          chain_q <= alu_flagout;
          state_q <= ST_HI;
        end
        ST_HI: begin
          rsp_data_q  <= {alu_result, byte_q};
          flag_q      <= alu_flagout;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_DONE;
        end
        ST_SHF: begin
          byte_q  <= alu_result;
          chain_q <= alu_flagout;
          if (cnt_q == CNT_W'(1)) begin
            rsp_data_q  <= {8'h00, alu_result};
            flag_q      <= alu_flagout;
            rsp_valid_q <= 1'b1;
            state_q     <= ST_DONE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_DONE: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef ALU_SEQ_PERF_EN
  logic [PERF_W-1:0] busy_q;
  logic [PERF_W-1:0] ops_q;

  assign perf_busy = busy_q;
  assign perf_ops  = ops_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
      ops_q  <= '0;
    end else begin
      if ((state_q != ST_IDLE) && (busy_q != '1)) busy_q <= busy_q + 1'b1;
      if ((state_q == ST_DONE) && rsp_ready && (ops_q != '1)) ops_q <= ops_q + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural 8-bit ALU closing the loop.
module tb_alu_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [1:0]  req_kind;
  logic [2:0]  req_cnt;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic        flag_q;
  logic [7:0]  alu_srcA;
  logic [7:0]  alu_srcB;
  logic [7:0]  alu_srcC;
  logic        alu_flagin;
  logic        alu_flipin;
  logic [8:0]  alu_control;
  logic [7:0]  alu_result;
  logic        alu_flagout;
`ifdef ALU_SEQ_PERF_EN
  logic [15:0] perf_busy;
  logic [15:0] perf_ops;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_kind    (req_kind),
    .req_cnt     (req_cnt),
    .req_a       (req_a),
    .req_b       (req_b),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .flag_q      (flag_q),
    .alu_srcA    (alu_srcA),
    .alu_srcB    (alu_srcB),
    .alu_srcC    (alu_srcC),
    .alu_flagin  (alu_flagin),
    .alu_flipin  (alu_flipin),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .alu_flagout (alu_flagout)
`ifdef ALU_SEQ_PERF_EN
    , .perf_busy (perf_busy)
    , .perf_ops  (perf_ops)
`endif
  );

  // Reference ALU: flag is carry for add, borrow for sub, shifted-out bit for shifts.
  logic [8:0] alu_wide;
  logic       alu_cin;
  always_comb begin
    alu_wide    = 9'h000;
    alu_result  = 8'h00;
    alu_flagout = 1'b0;
    alu_cin     = alu_control[6] & alu_flagin;
    if (alu_control[7]) begin
      case (alu_control[6:5])
        2'b00:   begin alu_result = {alu_srcA[7], alu_srcA[7:1]}; alu_flagout = alu_srcA[0]; end
        2'b01:   begin alu_result = {1'b0, alu_srcA[7:1]};        alu_flagout = alu_srcA[0]; end
        2'b10:   begin alu_result = {alu_flagin, alu_srcA[7:1]};  alu_flagout = alu_srcA[0]; end
        default: begin alu_result = {alu_srcA[6:0], alu_flagin};  alu_flagout = alu_srcA[7]; end
      endcase
    end else begin
      if (alu_control[5]) alu_wide = {1'b0, alu_srcA} - {1'b0, alu_srcB} - {8'h00, alu_cin};
      else                alu_wide = {1'b0, alu_srcA} + {1'b0, alu_srcB} + {8'h00, alu_cin};
      alu_result  = alu_wide[7:0];
      alu_flagout = alu_wide[8];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issues one op with rsp_ready high and checks first-pass control word, latency, data, flag.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [1:0] kind,
                       input logic [2:0] cnt, input logic [15:0] a, input logic [15:0] b,
                       input logic [8:0] exp_ctl, input int exp_lat,
                       input logic [15:0] exp_data, input logic exp_flag);
    int lat;
    check({tag, ".ready"}, req_ready, 1);
    req_valid = 1'b1; req_op = op; req_kind = kind; req_cnt = cnt; req_a = a; req_b = b;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    check({tag, ".ctl"}, alu_control, exp_ctl);
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".lat"}, lat, exp_lat);
    check({tag, ".data"}, rsp_data, exp_data);
    check({tag, ".flag"}, flag_q, exp_flag);
    $display("%s: op=%0d a=%h b=%h cnt=%0d -> data=%h flag=%0b lat=%0d",
             tag, op, a, b, cnt, rsp_data, flag_q, lat);
    @(posedge clk); #1;
    check({tag, ".idle"}, {rsp_valid, req_ready}, 2'b01);
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 3'd0; req_kind = 2'b00; req_cnt = 3'd0;
    req_a = 16'h0000; req_b = 16'h0000; rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    check("rst.valid", rsp_valid, 0);
    check("rst.data", rsp_data, 16'h0000);
    check("rst.flag", flag_q, 0);
    check("rst.ctl", alu_control, 9'h001);
    check("rst.ready", req_ready, 1);

    do_op("add16",   3'd0, 2'b00, 3'd0, 16'h00FF, 16'h0001, 9'h001, 3, 16'h0100, 1'b0);
    do_op("sub16",   3'd1, 2'b00, 3'd0, 16'h0000, 16'h0001, 9'h021, 3, 16'hFFFF, 1'b1);
    do_op("sbc16",   3'd3, 2'b00, 3'd0, 16'h0005, 16'h0001, 9'h061, 3, 16'h0003, 1'b0);
    do_op("srl3",    3'd4, 2'b01, 3'd3, 16'h0081, 16'h0000, 9'h0A1, 4, 16'h0010, 1'b0);
    do_op("sra2",    3'd4, 2'b00, 3'd2, 16'h0080, 16'h0000, 9'h081, 3, 16'h00E0, 1'b0);
    do_op("setflag", 3'd1, 2'b00, 3'd0, 16'h0000, 16'h0001, 9'h021, 3, 16'hFFFF, 1'b1);
    do_op("slf1",    3'd4, 2'b11, 3'd1, 16'h0081, 16'h0000, 9'h0E1, 2, 16'h0003, 1'b1);
    do_op("shf0",    3'd4, 2'b00, 3'd0, 16'h005A, 16'h0000, 9'h001, 1, 16'h005A, 1'b1);
    do_op("illegal", 3'd6, 2'b00, 3'd0, 16'h1234, 16'h0001, 9'h001, 1, 16'h0000, 1'b1);
    do_op("adc16",   3'd2, 2'b00, 3'd0, 16'h1234, 16'h0001, 9'h041, 3, 16'h1236, 1'b0);
    do_op("srf2",    3'd4, 2'b10, 3'd2, 16'h0003, 16'h0000, 9'h0C1, 3, 16'h0080, 1'b1);

    // Backpressure: response must hold while the consumer stalls.
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_op = 3'd4; req_kind = 2'b00; req_cnt = 3'd0; req_a = 16'h0033;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("hold.valid", rsp_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("hold.data", rsp_data, 16'h0033);
      check("hold.busy", {rsp_valid, req_ready}, 2'b10);
    end
    $display("hold: data=%h held 5 cycles", rsp_data);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("hold.release", {rsp_valid, req_ready}, 2'b01);

    // Reset in the middle of a long shift drops it without a response.
    req_valid = 1'b1; req_op = 3'd4; req_kind = 2'b00; req_cnt = 3'd7; req_a = 16'h0080;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    check("midrst.inshf", alu_control, 9'h081);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst.valid", rsp_valid, 0);
    check("midrst.flag", flag_q, 0);
    check("midrst.ctl", alu_control, 9'h001);
    check("midrst.ready", req_ready, 1);
    repeat (10) @(posedge clk);
    #1 check("midrst.norsp", rsp_valid, 0);
    $display("midrst: reset during shift, flag=%0b valid=%0b", flag_q, rsp_valid);

    do_op("postrst", 3'd0, 2'b00, 3'd0, 16'h0001, 16'h0002, 9'h001, 3, 16'h0003, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
